// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encoding, FSM states and
// the alignment rule.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    RSP  = 3'd3,
    ERR  = 3'd4
  } state_e;

  // Reserved size is always treated as a misaligned access.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Little-endian lane handling: merges store data into a read word and
// extracts/extends load data from it.
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  size_e       i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_merged,
  output logic [31:0] o_extracted
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

  // Store path: replace the addressed lane(s) of the read word
  always_comb begin
    o_merged = i_rdata;
    case (i_size)
      SZ_BYTE: o_merged[{i_addr_lo, 3'b000} +: 8]     = i_wdata[7:0];
      SZ_HALF: o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      SZ_WORD: o_merged = i_wdata;
      default: o_merged = i_rdata;
    endcase
  end

  // Load path: select the addressed lane and sign- or zero-extend it
  always_comb begin
    o_extracted = 32'd0;
    case (i_size)
      SZ_BYTE: o_extracted = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_extracted = {{16{~i_unsigned & w_half[15]}}, w_half};
      SZ_WORD: o_extracted = i_rdata;
      default: o_extracted = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit; sub-word stores use read-modify-write
// against a memory with one cycle of read latency.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  input  logic [31:0]       mem_data_out
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_live;
  logic              r_we;
  logic              r_unsigned;
  size_e             r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              w_accept;
  logic              w_misaligned;
  logic [ADDR_W-1:0] w_word_idx;
  logic [31:0]       w_merged;
  logic [31:0]       w_extracted;

  assign w_accept     = req_valid && req_ready;
  assign w_misaligned = is_misaligned(size_e'(req_size), req_addr[1:0]);
  assign w_word_idx   = {2'b00, r_addr[ADDR_W-1:2]};

  lsu_lane_merge u_lane (
    .i_size      (r_size),
    .i_addr_lo   (r_addr[1:0]),
    .i_unsigned  (r_unsigned),
    .i_wdata     (r_wdata),
    .i_rdata     (mem_data_out),
    .o_merged    (w_merged),
    .o_extracted (w_extracted)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Captured request; r_live holds req_ready low for the first cycle after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live     <= 1'b0;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= SZ_BYTE;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_we       <= req_we;
        r_unsigned <= req_unsigned;
        r_size     <= size_e'(req_size);
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
      end
    end
  end

  // Next-state: aligned word stores skip the read; everything else reads first
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!w_accept) begin
          w_state_nxt = IDLE;
        end else if (w_misaligned) begin
          w_state_nxt = ERR;
        end else if (req_we && (size_e'(req_size) == SZ_WORD)) begin
          w_state_nxt = WR;
        end else begin
          w_state_nxt = RD;
        end
      end
      RD:      w_state_nxt = r_we ? WR : RSP;
      WR:      w_state_nxt = IDLE;
      RSP:     w_state_nxt = IDLE;
      ERR:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    req_ready        = r_live && (r_state == IDLE);
    rsp_valid        = 1'b0;
    rsp_err          = 1'b0;
    rsp_rdata        = 32'd0;
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_data_in      = 32'd0;
    case (r_state)
      RD: begin
        mem_address = w_word_idx;
      end
      WR: begin
        mem_address      = w_word_idx;
        mem_write_enable = 1'b1;
        mem_data_in      = w_merged;
        rsp_valid        = 1'b1;
      end
      RSP: begin
        mem_address = w_word_idx;
        rsp_valid   = 1'b1;
        rsp_rdata   = w_extracted;
      end
      ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
      end
      default: begin
        rsp_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a one-cycle-latency memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out = 32'd0;

  int checks = 0;
  int errors = 0;
  int we_count = 0;

  logic [31:0] mem [256];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = 8'd0;
  logic [31:0] pre_data = 32'd0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_data;
    else if (mem_write_enable) mem[mem_address[7:0]] <= mem_data_in;
    if (!mem_write_enable) mem_data_out <= mem[mem_address[7:0]];
    if (mem_write_enable) we_count <= we_count + 1;
  end

  task automatic preset(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_idx = idx; pre_data = data; pre_en = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  // Presents a request at a negedge, lets one edge accept it, then drops valid.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL issue_ready: got %b want 1", req_ready); end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_write_enable} !== 4'b0000 || rsp_rdata !== 32'd0 ||
        mem_address !== 32'd0 || mem_data_in !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b rv=%b re=%b we=%b rd=%h ad=%h di=%h want all 0",
               req_ready, rsp_valid, rsp_err, mem_write_enable, rsp_rdata, mem_address, mem_data_in);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: got %b want 1", req_ready); end
  endtask

  task automatic test_word_store();
    int wc;
    wc = we_count;
    issue(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if (mem_write_enable !== 1'b1 || mem_address !== 32'h40 || mem_data_in !== 32'hDEADBEEF ||
        rsp_valid !== 1'b1 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL word_store_wr: we=%b ad=%h di=%h rv=%b re=%b rdy=%b want 1/40/deadbeef/1/0/0",
               mem_write_enable, mem_address, mem_data_in, rsp_valid, rsp_err, req_ready);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem[8'h40] !== 32'hDEADBEEF || we_count != wc + 1) begin
      errors++;
      $display("FAIL word_store_after: rv=%b rdy=%b mem=%h wes=%0d want 0/1/deadbeef/%0d",
               rsp_valid, req_ready, mem[8'h40], we_count - wc, 1);
    end
  endtask

  task automatic test_subword_store();
    preset(8'h40, 32'h11223344);
    issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h000000AB);
    @(negedge clk);
    checks++;
    if (mem_write_enable !== 1'b0 || rsp_valid !== 1'b0 || mem_address !== 32'h40) begin
      errors++;
      $display("FAIL byte_store_rd: we=%b rv=%b ad=%h want 0/0/40", mem_write_enable, rsp_valid, mem_address);
    end
    @(negedge clk);
    checks++;
    if (mem_write_enable !== 1'b1 || mem_data_in !== 32'hAB223344 || rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL byte_store_wr: we=%b di=%h rv=%b re=%b want 1/ab223344/1/0",
               mem_write_enable, mem_data_in, rsp_valid, rsp_err);
    end
    issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h12349999);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_write_enable !== 1'b1 || mem_data_in !== 32'h99993344 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL half_store_wr: we=%b di=%h rv=%b want 1/99993344/1", mem_write_enable, mem_data_in, rsp_valid);
    end
  endtask

  task automatic test_loads();
    int wc;
    preset(8'h40, 32'h80017F00);
    wc = we_count;
    issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || mem_write_enable !== 1'b0 || rsp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL load_rd: rv=%b we=%b rd=%h want 0/0/0", rsp_valid, mem_write_enable, rsp_rdata);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hFFFF8001 || mem_address !== 32'h40) begin
      errors++;
      $display("FAIL half_signed_load: rv=%b re=%b rd=%h ad=%h want 1/0/ffff8001/40",
               rsp_valid, rsp_err, rsp_rdata, mem_address);
    end
    issue(1'b0, 2'b00, 1'b1, 32'h101, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000007F) begin
      errors++;
      $display("FAIL byte_unsigned_load: rv=%b rd=%h want 1/0000007f", rsp_valid, rsp_rdata);
    end
    issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp_rdata !== 32'hFFFFFF80 || we_count != wc) begin
      errors++;
      $display("FAIL byte_signed_load: rd=%h wes=%0d want ffffff80/0", rsp_rdata, we_count - wc);
    end
  endtask

  task automatic test_misaligned();
    int wc;
    wc = we_count;
    issue(1'b0, 2'b01, 1'b0, 32'h101, 32'h0);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || mem_write_enable !== 1'b0 || mem_address !== 32'd0) begin
      errors++;
      $display("FAIL err_half_load: rv=%b re=%b we=%b ad=%h want 1/1/0/0",
               rsp_valid, rsp_err, mem_write_enable, mem_address);
    end
    issue(1'b1, 2'b10, 1'b0, 32'h102, 32'h55555555);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || mem_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL err_word_store: rv=%b re=%b we=%b want 1/1/0", rsp_valid, rsp_err, mem_write_enable);
    end
    issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL err_rsvd_size: rv=%b re=%b want 1/1", rsp_valid, rsp_err);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || req_ready !== 1'b1 || we_count != wc) begin
      errors++;
      $display("FAIL err_after: rv=%b re=%b rdy=%b wes=%0d want 0/0/1/0",
               rsp_valid, rsp_err, req_ready, we_count - wc);
    end
  endtask

  task automatic test_reset_in_wr();
    int wc;
    preset(8'h40, 32'h11223344);
    wc = we_count;
    issue(1'b1, 2'b00, 1'b0, 32'h100, 32'h00000055);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_write_enable !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_wr: we=%b rv=%b rdy=%b want 0/0/0", mem_write_enable, rsp_valid, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (mem[8'h40] !== 32'h11223344 || we_count != wc || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mem_kept: mem=%h wes=%0d rdy=%b want 11223344/0/0", mem[8'h40], we_count - wc, req_ready);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_release_ready: rdy=%b rv=%b want 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic        t_we  [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  t_sz  [3] = '{2'b10, 2'b10, 2'b00};
    logic [31:0] t_ad  [3] = '{32'h100, 32'h104, 32'h107};
    logic [31:0] t_wd  [3] = '{32'h0, 32'hCAFEF00D, 32'h0};
    logic [31:0] t_exp [3] = '{32'h12345678, 32'h0, 32'hFFFFFFCA};
    int          t_lat [3] = '{2, 1, 2};
    int n;
    int lat;
    int extra;
    int wc;
    preset(8'h40, 32'h12345678);
    wc = we_count;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      req_we = t_we[i]; req_size = t_sz[i]; req_unsigned = 1'b0;
      req_addr = t_ad[i]; req_wdata = t_wd[i]; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 10) begin @(negedge clk); n++; end
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!rsp_valid && lat < 10);
      checks++;
      if (lat != t_lat[i] || rsp_err !== 1'b0 || (!t_we[i] && rsp_rdata !== t_exp[i])) begin
        errors++;
        $display("FAIL b2b_txn%0d: lat=%0d err=%b rd=%h want lat=%0d err=0 rd=%h",
                 i, lat, rsp_err, rsp_rdata, t_lat[i], t_exp[i]);
      end
    end
    req_valid = 1'b0;
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) extra++;
    end
    checks++;
    if (extra != 0 || we_count != wc + 1 || mem[8'h41] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL b2b_tail: extra_rsp=%0d wes=%0d mem=%h want 0/1/cafef00d", extra, we_count - wc, mem[8'h41]);
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_subword_store();
    test_loads();
    test_misaligned();
    test_reset_in_wr();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_W, default 32, byte-address width on the core side and the memory side.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid  input  1  core request valid.
REQ-005 Port: req_ready  output  1  unit can accept a request.
REQ-006 Port: req_we  input  1  1 = store, 0 = load.
REQ-007 Port: req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 Port: req_unsigned  input  1  zero-extend load (1) or sign-extend load (0).
REQ-009 Port: req_addr  input  ADDR_W  byte address.
REQ-010 Port: req_wdata  input  32  store data, right-aligned.
REQ-011 Port: rsp_valid  output  1  one-cycle completion pulse.
REQ-012 Port: rsp_err  output  1  misaligned or reserved-size access; qualified by rsp_valid.
REQ-013 Port: rsp_rdata  output  32  extended load data; qualified by rsp_valid and !req_we.
REQ-014 Port: mem_write_enable  output  1  memory write strobe; memory reads whenever low.
REQ-015 Port: mem_address  output  ADDR_W  word index = captured address >> 2.
REQ-016 Port: mem_data_in  output  32  full write word.
REQ-017 Port: mem_data_out  input  32  memory read word, valid the cycle after a read address is presented.

Function
REQ-018 The unit SHALL use FSM states IDLE, RD, WR, RSP and ERR.
REQ-019 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a clock edge where req_valid && req_ready, capturing all req_* fields.
REQ-020 Misalignment SHALL be: half with addr[0]=1, word with addr[1:0]!=0, or size 11; acceptance then SHALL go to ERR.
REQ-021 ERR SHALL drive rsp_valid=1 and rsp_err=1 for one cycle with mem_write_enable=0, then return to IDLE.
REQ-022 Aligned word store SHALL go IDLE->WR: mem_write_enable=1, mem_data_in=wdata, rsp_valid=1 in WR, then IDLE (response 1 cycle after acceptance).
REQ-023 Byte/half store SHALL go IDLE->RD->WR (read-modify-write).
- In WR, mem_data_in SHALL be mem_data_out with lane(s) addr[1:0] (byte) or addr[1] (half) replaced by the low bits of wdata (little-endian).
- rsp_valid SHALL be 1 in WR (2 cycles after acceptance).
REQ-024 Load SHALL go IDLE->RD->RSP.
- In RSP, rsp_rdata SHALL be the selected lane of mem_data_out, sign- or zero-extended per req_unsigned; rsp_valid=1 (2 cycles after acceptance).
REQ-025 In RD and RSP, mem_write_enable SHALL be 0.
REQ-026 mem_address SHALL hold the captured word index in RD, WR and RSP, and SHALL be 0 in IDLE/ERR.
REQ-027 mem_write_enable SHALL be asserted for exactly one cycle per successful store and never for loads or errors.
REQ-028 rsp_err SHALL be 0 whenever rsp_valid=0 or the access is aligned; rsp_rdata SHALL be 0 when not a load response.
REQ-029 A request presented back-to-back SHALL be accepted in the IDLE cycle immediately following a response, giving no lost or duplicated transactions.
REQ-030 req_* changes while req_ready=0 SHALL have no effect.

Reset
REQ-031 While rst_n=0, asynchronously: state=IDLE; req_ready=0; rsp_valid=0; rsp_err=0; rsp_rdata=0; mem_write_enable=0; mem_address=0; mem_data_in=0; captured fields cleared.
REQ-032 Reset during RD or WR SHALL abort with no memory write and no response; req_ready SHALL rise the first cycle after rst_n deasserts.

Structure
REQ-033 A shared package lsu_pkg SHALL hold the size encoding enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD) and the FSM state enum.
REQ-034 Lane merge and extract SHALL live in one combinational sub-module, lsu_lane_merge, instantiated once.

Verification
REQ-035 Scenario: word store addr 0x100, data 0xDEADBEEF -> one WR cycle with mem_address=0x40, mem_data_in=0xDEADBEEF, rsp_valid 1 cycle after acceptance.
REQ-036 Scenario: memory[0x40]=0x11223344; byte store addr 0x103, data 0xAB -> RD then WR with mem_data_in=0xAB223344, rsp_valid 2 cycles after acceptance.
REQ-037 Scenario: memory[0x40]=0x8001_7F00.
- Signed half load addr 0x102 -> rsp_rdata=0xFFFF8001.
- Unsigned byte load addr 0x101 -> rsp_rdata=0x0000007F.
REQ-038 Scenario: half load addr 0x101, word store addr 0x102 -> each gives rsp_valid=1, rsp_err=1, and mem_write_enable never asserted.
REQ-039 Scenario: rst_n pulled low in WR of a byte store -> mem_write_enable=0 immediately, no rsp_valid, memory word unchanged.
REQ-040 Scenario: back-to-back requests with req_valid held high -> each accepted only in IDLE, with responses in order.
